// File: rtl/debug_frame_tx.sv
// debug_frame_tx
// Captures a wide debug word on a synchronized rising edge of snap_req and
// streams it to a UART byte transmitter as a framed packet:
//   HDR, SEQ, payload bytes (MSB first), XOR checksum over SEQ and payload.
// One byte moves per tx_valid/tx_ready handshake. All outputs are registered,
// and each output is computed from the next-state values so that it lines up
// with the state it describes.

module debug_frame_tx #(
    parameter int          NBYTES = 8,
    parameter logic [7:0]  HDR    = 8'hA5
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst_n,
    input  logic                  snap_req,
    input  logic [8*NBYTES-1:0]   snap_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic [7:0]            frame_cnt,
    output logic                  overrun
);

    // Payload index width; at least one bit so NBYTES=1 still has a legal vector.
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_SEQ  = 3'd2,
        ST_PAY  = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    // Running checksum fold: 8-bit XOR accumulation.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // Byte i of the shadow word; byte NBYTES-1 is the most significant.
    function automatic logic [7:0] pay_byte(input logic [8*NBYTES-1:0] w,
                                            input logic [IDX_W-1:0]    i);
        return w[{i, 3'b000} +: 8];
    endfunction

    // Synchronizer and edge detector for the CPU-domain request.
    logic s1_q, s2_q, s3_q;
    logic rise_s;
    logic accept_s;

    state_t                 state_q,     state_d;
    logic [8*NBYTES-1:0]    shadow_q,    shadow_d;
    logic [7:0]             seq_q,       seq_d;
    logic [7:0]             chk_q,       chk_d;
    logic [IDX_W-1:0]       idx_q,       idx_d;
    logic [7:0]             frame_cnt_q, frame_cnt_d;
    logic                   overrun_q,   overrun_d;
    logic [7:0]             tx_data_q,   tx_data_d;
    logic                   tx_valid_q,  tx_valid_d;
    logic                   busy_q,      busy_d;

    // Three-flop chain: two for metastability, the third remembers the last level.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= snap_req;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise_s   = s2_q & ~s3_q;
    assign accept_s = tx_valid_q & tx_ready;

    // Next-state, datapath updates and next output values for the framer.
    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        seq_d       = seq_q;
        chk_d       = chk_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        // A request edge seen while a frame is running is dropped and remembered.
        overrun_d   = overrun_q | (rise_s & (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    shadow_d = snap_data;
                    seq_d    = frame_cnt_q;
                    chk_d    = 8'h00;
                    idx_d    = IDX_W'(NBYTES - 1);
                    state_d  = ST_HDR;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (accept_s) begin
                    state_d = ST_SEQ;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_SEQ: begin
                if (accept_s) begin
                    chk_d   = chk_fold(chk_q, seq_q);
                    state_d = ST_PAY;
                end else begin
                    state_d = ST_SEQ;
                end
            end
            ST_PAY: begin
                if (accept_s) begin
                    chk_d = chk_fold(chk_q, pay_byte(shadow_q, idx_q));
                    if (idx_q == {IDX_W{1'b0}}) begin
                        state_d = ST_CHK;
                    end else begin
                        idx_d   = idx_q - {{(IDX_W-1){1'b0}}, 1'b1};
                        state_d = ST_PAY;
                    end
                end else begin
                    state_d = ST_PAY;
                end
            end
            ST_CHK: begin
                if (accept_s) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_CHK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs for the coming cycle follow the state being entered, so a
        // stalled byte is recomputed from unchanged registers and stays put.
        tx_valid_d = (state_d != ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        case (state_d)
            ST_IDLE: tx_data_d = 8'h00;
            ST_HDR:  tx_data_d = HDR;
            ST_SEQ:  tx_data_d = seq_d;
            ST_PAY:  tx_data_d = pay_byte(shadow_d, idx_d);
            ST_CHK:  tx_data_d = chk_d;
            default: tx_data_d = 8'h00;
        endcase
    end

    // Framer state, datapath and registered outputs.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shadow_q    <= '0;
            seq_q       <= 8'h00;
            chk_q       <= 8'h00;
            idx_q       <= {IDX_W{1'b0}};
            frame_cnt_q <= 8'h00;
            overrun_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            seq_q       <= seq_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: table of frames checked through a byte scoreboard,
// plus hand sequences for overrun, asynchronous reset and sequence-number wrap.

module tb_debug_frame_tx;

    localparam int NB = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            snap_req;
    logic [8*NB-1:0] snap_data;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            busy;
    logic [7:0]      frame_cnt;
    logic            overrun;

    // Second instance with a one-byte payload for the counter wrap sequence.
    logic            snap_req1;
    logic [7:0]      snap_data1;
    logic [7:0]      tx_data1;
    logic            tx_valid1;
    logic            tx_ready1;
    logic            busy1;
    logic [7:0]      frame_cnt1;
    logic            overrun1;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    int         ready_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
    bit         mon_hold   = 1'b1;
    int         stall_left = 0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    typedef struct {
        logic [63:0] data;
        int          mode;
        logic [7:0]  exp_seq;
        logic [7:0]  exp_chk;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    debug_frame_tx #(.NBYTES(NB), .HDR(8'hA5)) u_dut (
        .CLK100MHZ (clk),
        .rst_n     (rst_n),
        .snap_req  (snap_req),
        .snap_data (snap_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt),
        .overrun   (overrun)
    );

    debug_frame_tx #(.NBYTES(1), .HDR(8'hA5)) u_dut1 (
        .CLK100MHZ (clk),
        .rst_n     (rst_n),
        .snap_req  (snap_req1),
        .snap_data (snap_data1),
        .tx_data   (tx_data1),
        .tx_valid  (tx_valid1),
        .tx_ready  (tx_ready1),
        .busy      (busy1),
        .frame_cnt (frame_cnt1),
        .overrun   (overrun1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Ready driver and scoreboard: at each falling edge pick tx_ready for the
    // next rising edge, then score the handshake that edge will complete.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_hold) begin
                prev_stall = 1'b0;
            end else begin
                case (ready_mode)
                    0: tx_ready = 1'b1;
                    1: begin
                        if (stall_left > 0) begin
                            tx_ready   = 1'b0;
                            stall_left = stall_left - 1;
                        end else begin
                            tx_ready   = 1'b1;
                            stall_left = $urandom_range(0, 5);
                        end
                    end
                    2: tx_ready = 1'b0;
                    default: tx_ready = 1'b1;
                endcase
                if (prev_stall) begin
                    chk("hold_valid", tx_valid, 1'b1);
                    chk("hold_data", tx_data, prev_data);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_byte actual=%0h required=none", tx_data);
                    end else begin
                        chk("byte", tx_data, exp_q.pop_front());
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
            end
        end
    end

    task automatic push_frame(input logic [63:0] d, input logic [7:0] seq, input logic [7:0] c);
        logic [63:0] w;
        w = d;
        exp_q.push_back(8'hA5);
        exp_q.push_back(seq);
        for (int b = NB - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
        exp_q.push_back(c);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(name, busy, 1'b0);
    endtask

    task automatic run_frame(input vec_t v);
        int lat;
        push_frame(v.data, v.exp_seq, v.exp_chk);
        ready_mode = v.mode;
        snap_data  = v.data;
        @(negedge clk);
        snap_req = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!tx_valid && lat < 20);
        chk("latency", lat, 3);
        wait_idle("frame_end");
        snap_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("frame_cnt", frame_cnt, v.exp_cnt);
        chk("idle_valid", tx_valid, 1'b0);
    endtask

    task automatic run_frame1(output bit timeout);
        int n;
        n = 0;
        timeout = 1'b0;
        @(negedge clk);
        snap_req1 = 1'b1;
        while (!busy1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        while (busy1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20 && busy1) timeout = 1'b1;
        if (n >= 60) timeout = 1'b1;
        snap_req1 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int         n;
        int         cnt;
        int         tmo;
        bit         t;
        logic [7:0] cap[4];

        vecs[0] = '{64'h0123456789ABCDEF, 0, 8'h00, 8'h00, 8'd1};
        vecs[1] = '{64'h0123456789ABCDEF, 0, 8'h01, 8'h01, 8'd2};
        vecs[2] = '{64'h0123456789ABCDEF, 1, 8'h02, 8'h02, 8'd3};
        vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 1, 8'h03, 8'h03, 8'd4};
        vecs[4] = '{64'h8000000000000001, 1, 8'h04, 8'h85, 8'd5};

        rst_n      = 1'b0;
        snap_req   = 1'b0;
        snap_data  = '0;
        snap_req1  = 1'b0;
        snap_data1 = 8'h3C;
        tx_ready1  = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_cnt", frame_cnt, 8'h00);
        chk("rst_overrun", overrun, 1'b0);
        rst_n    = 1'b1;
        mon_hold = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);
        chk("overrun_clear", overrun, 1'b0);

        // Second request edge while the payload is stalled.
        push_frame(64'h0123456789ABCDEF, 8'h05, 8'h05);
        ready_mode = 0;
        snap_data  = 64'h0123456789ABCDEF;
        @(negedge clk);
        snap_req = 1'b1;
        n = 0;
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1 ready_mode = 2;
        snap_req = 1'b0;
        repeat (3) @(negedge clk);
        snap_req = 1'b1;
        snap_data = 64'hDEADBEEFDEADBEEF;
        repeat (4) @(negedge clk);
        chk("ovr_flag", overrun, 1'b1);
        chk("ovr_busy", busy, 1'b1);
        chk("ovr_pay_byte", tx_data, 8'h01);
        @(posedge clk);
        #1 ready_mode = 0;
        wait_idle("ovr_frame_end");
        repeat (10) @(negedge clk);
        chk("ovr_no_second", busy, 1'b0);
        chk("ovr_frame_cnt", frame_cnt, 8'd6);
        chk("ovr_queue", exp_q.size(), 0);
        snap_req = 1'b0;
        repeat (3) @(negedge clk);

        run_frame('{64'h0123456789ABCDEF, 1, 8'h06, 8'h06, 8'd7});
        chk("ovr_sticky", overrun, 1'b1);

        // Asynchronous reset while the SEQ byte is stalled.
        exp_q.push_back(8'hA5);
        ready_mode = 0;
        snap_data  = 64'h0123456789ABCDEF;
        @(negedge clk);
        snap_req = 1'b1;
        n = 0;
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 ready_mode = 2;
        @(negedge clk);
        chk("seq_shown", tx_data, 8'h07);
        chk("seq_valid", tx_valid, 1'b1);
        mon_hold = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tx_valid", tx_valid, 1'b0);
        chk("arst_tx_data", tx_data, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_frame_cnt", frame_cnt, 8'h00);
        chk("arst_overrun", overrun, 1'b0);
        snap_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        mon_hold = 1'b0;
        chk("arst_queue", exp_q.size(), 0);
        run_frame('{64'h0123456789ABCDEF, 0, 8'h00, 8'h00, 8'd1});

        // Sequence number wrap on the one-byte instance.
        tmo = 0;
        for (int f = 0; f < 255; f++) begin
            run_frame1(t);
            if (t) tmo++;
        end
        chk("wrap_timeouts", tmo, 0);
        chk("wrap_cnt_255", frame_cnt1, 8'd255);
        @(negedge clk);
        snap_req1 = 1'b1;
        n = 0;
        cnt = 0;
        while (cnt < 4 && n < 40) begin
            @(negedge clk);
            if (tx_valid1) begin
                cap[cnt] = tx_data1;
                cnt++;
            end
            n++;
        end
        chk("wrap_bytes", cnt, 4);
        chk("wrap_hdr", cap[0], 8'hA5);
        chk("wrap_seq", cap[1], 8'hFF);
        chk("wrap_pay", cap[2], 8'h3C);
        chk("wrap_chk", cap[3], 8'hC3);
        @(negedge clk);
        chk("wrap_busy", busy1, 1'b0);
        chk("wrap_cnt_0", frame_cnt1, 8'h00);
        snap_req1 = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
